// File: rtl/apple1_bus_if.sv
// CPU-side bus bundle between the Apple-1 bus controller and the CPU core,
// memories, keyboard source and display sink.
interface apple1_bus_if;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_clken;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  rom_dout;
  logic        kbd_valid;
  logic [6:0]  kbd_data;
  logic        kbd_ack;
  logic        dsp_valid;
  logic [6:0]  dsp_data;
  logic        dsp_ready;

  modport master (
    input  cpu_ab, cpu_we, cpu_dout, ram_dout, rom_dout,
           kbd_valid, kbd_data, dsp_ready,
    output cpu_din, cpu_clken, ram_we, kbd_ack, dsp_valid, dsp_data
  );

  modport slave (
    output cpu_ab, cpu_we, cpu_dout, ram_dout, rom_dout,
           kbd_valid, kbd_data, dsp_ready,
    input  cpu_din, cpu_clken, ram_we, kbd_ack, dsp_valid, dsp_data
  );
endinterface

// File: rtl/apple1_bus_ctrl.sv
// Apple-1 CPU bus controller: CPU clock enable, address decode, read-data mux
// aligned to 1-clk registered memories, and the PIA keyboard/display registers.
module apple1_bus_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RAM_SIZE = 'h2000,
  parameter logic [7:0]  ROM_PAGE = 8'hFF,
  parameter logic [15:0] PIA_BASE = 16'hD010
) (
  input  logic         clk,
  input  logic         rst,
  apple1_bus_if.master bus
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [16:0]      RAM_LIM  = 17'(RAM_SIZE);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_ROM  = 2'd2;
  localparam logic [1:0] SEL_PIA  = 2'd3;

  localparam logic [1:0] REG_KBD   = 2'd0;
  localparam logic [1:0] REG_KBDCR = 2'd1;
  localparam logic [1:0] REG_DSP   = 2'd2;

  logic [DIV_W-1:0] div_q, div_d;
  logic             clken_q, clken_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ab_q;
  logic             kbd_full_q, kbd_full_d;
  logic [6:0]       kbd_q, kbd_d;
  logic             dsp_valid_q, dsp_valid_d;
  logic [6:0]       dsp_data_q, dsp_data_d;
  logic             kbd_rd, dsp_wr, kbd_take;
  logic [7:0]       pia_rdata;
  logic             unused_bits;

  // Counter wraps at CLK_DIV-1; the enable is registered so it coincides with
  // the cycle in which the counter holds its last value.
  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    clken_d = (div_d == DIV_LAST);
  end

  always_comb begin
    sel_d = SEL_NONE;
    if (bus.cpu_ab[15:8] == ROM_PAGE)
      sel_d = SEL_ROM;
    else if (bus.cpu_ab[15:2] == PIA_BASE[15:2])
      sel_d = SEL_PIA;
    else if ({1'b0, bus.cpu_ab} < RAM_LIM)
      sel_d = SEL_RAM;
  end

  assign kbd_rd   = clken_q & ~bus.cpu_we & (sel_d == SEL_PIA) & (bus.cpu_ab[1:0] == REG_KBD);
  assign dsp_wr   = clken_q &  bus.cpu_we & (sel_d == SEL_PIA) & (bus.cpu_ab[1:0] == REG_DSP);
  // A CPU read that empties the latch in this clk frees it for a new key.
  assign kbd_take = ~rst & bus.kbd_valid & (~kbd_full_q | kbd_rd);

  always_comb begin
    kbd_full_d = kbd_full_q;
    kbd_d      = kbd_q;
    if (kbd_take) begin
      kbd_full_d = 1'b1;
      kbd_d      = bus.kbd_data;
    end else if (kbd_rd) begin
      kbd_full_d = 1'b0;
    end
  end

  // Sink handshake has priority: a write landing while a char is pending is lost.
  always_comb begin
    dsp_valid_d = dsp_valid_q;
    dsp_data_d  = dsp_data_q;
    if (dsp_valid_q) begin
      if (bus.dsp_ready) dsp_valid_d = 1'b0;
    end else if (dsp_wr) begin
      dsp_valid_d = 1'b1;
      dsp_data_d  = bus.cpu_dout[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      clken_q     <= 1'b0;
      sel_q       <= SEL_NONE;
      ab_q        <= 2'd0;
      kbd_full_q  <= 1'b0;
      kbd_q       <= 7'd0;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= 7'd0;
    end else begin
      div_q       <= div_d;
      clken_q     <= clken_d;
      sel_q       <= sel_d;
      ab_q        <= bus.cpu_ab[1:0];
      kbd_full_q  <= kbd_full_d;
      kbd_q       <= kbd_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
    end
  end

  always_comb begin
    case (ab_q)
      REG_KBD:   pia_rdata = {1'b1, kbd_q};
      REG_KBDCR: pia_rdata = {kbd_full_q, 7'b0};
      REG_DSP:   pia_rdata = {dsp_valid_q, 7'b0};
      default:   pia_rdata = 8'h00;
    endcase
  end

  // Select is registered one clk behind the address to match memory latency.
  always_comb begin
    case (sel_q)
      SEL_RAM: bus.cpu_din = bus.ram_dout;
      SEL_ROM: bus.cpu_din = bus.rom_dout;
      SEL_PIA: bus.cpu_din = pia_rdata;
      default: bus.cpu_din = 8'h00;
    endcase
  end

  assign bus.cpu_clken = clken_q;
  assign bus.ram_we    = bus.cpu_we & (sel_d == SEL_RAM) & clken_q;
  assign bus.kbd_ack   = kbd_take;
  assign bus.dsp_valid = dsp_valid_q;
  assign bus.dsp_data  = dsp_data_q;

  assign unused_bits = bus.cpu_dout[7];

endmodule
